// File: rtl/qspi_flash_responder.sv
// ============================================================================
// Module   : qspi_flash_responder
// Purpose  : Behavioural SPI NOR-flash responder (256-byte array, status/ID).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module qspi_flash_responder #(
   parameter logic [7:0] P_MFR_ID      = 8'hEF,
   parameter logic [7:0] P_DEV_ID      = 8'h16,
   parameter int         P_BUSY_CYCLES = 64
) (
   input  logic       I_clk,
   input  logic       I_rst_n,
   input  logic       I_qspi_clk,
   input  logic       I_qspi_cs,
   input  logic       I_qspi_mosi,
   output logic       O_qspi_miso,
   output logic       O_busy,
   output logic       O_wel,
   output logic [2:0] O_resp_state
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_DOUT   = 3'd3,
      ST_DIN    = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

   localparam int c_cnt_w = $clog2(P_BUSY_CYCLES + 1);

   state_t               r_state, w_state_nxt;
   logic [2:0]           r_sck_s, r_cs_s;
   logic [1:0]           r_mosi_s;
   logic [6:0]           r_shift_in;
   logic [4:0]           r_bit_cnt;
   logic [7:0]           r_opcode, r_addr, r_shift_out;
   logic [2:0]           r_out_cnt;
   logic                 r_miso, r_wr_en, r_wrote, r_extra, r_busy, r_wel;
   logic [c_cnt_w-1:0]   r_busy_cnt;
   logic [7:0]           w_mem_rd [256];
   logic [7:0]           w_byte, w_load_op, w_load_addr, w_load_byte;
   logic                 w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
   logic                 w_enter_dout, w_mem_we, w_erase, w_prog_done, w_wel_cmd;

   // [1] is the synchronized sample, [2] the previous one for edge detection
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_sck_s  <= '0;
         r_cs_s   <= '0;
         r_mosi_s <= '0;
      end else begin
         r_sck_s  <= {r_sck_s[1:0], I_qspi_clk};
         r_cs_s   <= {r_cs_s[1:0], I_qspi_cs};
         r_mosi_s <= {r_mosi_s[0], I_qspi_mosi};
      end
   end

   assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2];
   assign w_sck_fall = ~r_sck_s[1] & r_sck_s[2];
   assign w_cs_rise  = r_cs_s[1] & ~r_cs_s[2];
   assign w_cs_fall  = ~r_cs_s[1] & r_cs_s[2];
   assign w_byte     = {r_shift_in, r_mosi_s[1]};

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_cs_rise) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_cs_fall) w_state_nxt = ST_CMD;
            ST_CMD: begin
               if (w_sck_rise && r_bit_cnt == 5'd7) begin
                  if (r_busy) begin
                     w_state_nxt = (w_byte == 8'h05) ? ST_DOUT : ST_IGNORE;
                  end else begin
                     case (w_byte)
                        8'h05:                      w_state_nxt = ST_DOUT;
                        8'h90, 8'h03, 8'h02, 8'h20: w_state_nxt = ST_ADDR;
                        default:                    w_state_nxt = ST_IGNORE;
                     endcase
                  end
               end
            end
            ST_ADDR: begin
               if (w_sck_rise && r_bit_cnt == 5'd23) begin
                  case (r_opcode)
                     8'h90, 8'h03: w_state_nxt = ST_DOUT;
                     8'h02:        w_state_nxt = ST_DIN;
                     default:      w_state_nxt = ST_IGNORE;
                  endcase
               end
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   assign w_enter_dout = (w_state_nxt == ST_DOUT) && (r_state != ST_DOUT);
   assign w_load_op    = (r_state == ST_CMD) ? w_byte : r_opcode;
   assign w_load_addr  = (r_state == ST_ADDR) ? w_byte : r_addr + 8'd1;

   always_comb begin
      w_load_byte = w_mem_rd[w_load_addr];
      case (w_load_op)
         8'h05:   w_load_byte = {6'b0, r_wel, r_busy};
         8'h90:   w_load_byte = w_load_addr[0] ? P_DEV_ID : P_MFR_ID;
         default: w_load_byte = w_mem_rd[w_load_addr];
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_shift_in  <= '0;
         r_bit_cnt   <= '0;
         r_opcode    <= '0;
         r_addr      <= '0;
         r_shift_out <= '0;
         r_out_cnt   <= '0;
         r_miso      <= 1'b0;
         r_wr_en     <= 1'b0;
         r_wrote     <= 1'b0;
         r_extra     <= 1'b0;
      end else begin
         if (r_state != ST_DOUT) r_miso <= 1'b0;
         if (w_cs_rise || w_cs_fall) begin
            r_shift_in <= '0;
            r_bit_cnt  <= '0;
            r_out_cnt  <= '0;
            r_wrote    <= 1'b0;
            r_extra    <= 1'b0;
         end else begin
            if (w_sck_rise) begin
               r_shift_in <= w_byte[6:0];
               case (r_state)
                  ST_CMD: begin
                     if (r_bit_cnt == 5'd7) begin
                        r_bit_cnt <= '0;
                        // a suppressed opcode while busy must not act at CS rise
                        r_opcode  <= (r_busy && w_byte != 8'h05) ? 8'h00 : w_byte;
                        r_wr_en   <= r_wel && !r_busy;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                     end
                  end
                  ST_ADDR: begin
                     if (r_bit_cnt == 5'd23) begin
                        r_bit_cnt <= '0;
                        r_addr    <= w_byte;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                     end
                  end
                  ST_DIN: begin
                     if (r_bit_cnt == 5'd7) begin
                        r_bit_cnt <= '0;
                        r_addr    <= r_addr + 8'd1;
                        if (r_wr_en) r_wrote <= 1'b1;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                     end
                  end
                  ST_IGNORE: r_extra <= 1'b1;
                  default: r_extra <= r_extra;
               endcase
            end
            if (w_enter_dout) begin
               r_shift_out <= w_load_byte;
               r_out_cnt   <= '0;
            end else if (r_state == ST_DOUT && w_sck_fall) begin
               r_miso    <= r_shift_out[7];
               r_out_cnt <= r_out_cnt + 3'd1;
               if (r_out_cnt == 3'd7) begin
                  r_shift_out <= w_load_byte;
                  r_addr      <= w_load_addr;
               end else begin
                  r_shift_out <= {r_shift_out[6:0], 1'b0};
               end
            end
         end
      end
   end

   assign w_mem_we    = w_sck_rise && !w_cs_rise && !w_cs_fall && r_state == ST_DIN
                        && r_bit_cnt == 5'd7 && r_wr_en;
   assign w_erase     = w_cs_rise && r_state == ST_IGNORE && r_opcode == 8'h20
                        && r_wel && !r_busy;
   assign w_prog_done = w_cs_rise && r_state == ST_DIN && r_wrote;
   assign w_wel_cmd   = w_cs_rise && r_state == ST_IGNORE && !r_extra;

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         r_busy     <= 1'b0;
         r_wel      <= 1'b0;
         r_busy_cnt <= '0;
      end else if (w_erase || w_prog_done) begin
         r_busy     <= 1'b1;
         r_busy_cnt <= c_cnt_w'(P_BUSY_CYCLES - 1);
      end else if (r_busy) begin
         if (r_busy_cnt == '0) begin
            r_busy <= 1'b0;
            r_wel  <= 1'b0;
         end else begin
            r_busy_cnt <= r_busy_cnt - 1'b1;
         end
      end else if (w_wel_cmd) begin
         if (r_opcode == 8'h06)      r_wel <= 1'b1;
         else if (r_opcode == 8'h04) r_wel <= 1'b0;
      end
   end

   // Array is deliberately left unreset; each byte owns its register
   genvar g;
   generate
      for (g = 0; g < 256; g++) begin : g_mem
         logic [7:0] r_byte;
         always_ff @(posedge I_clk) begin
            if (w_erase)
               r_byte <= 8'hFF;
            else if (w_mem_we && r_addr == 8'(g))
               r_byte <= r_byte & w_byte;
         end
         assign w_mem_rd[g] = r_byte;
      end
   endgenerate

   assign O_qspi_miso  = r_miso;
   assign O_busy       = r_busy;
   assign O_wel        = r_wel;
   assign O_resp_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_qspi_flash_responder.sv
// ============================================================================
// Module   : tb_qspi_flash_responder
// Purpose  : Scoreboard bench for qspi_flash_responder (SPI mode 0 initiator).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qspi_flash_responder;

   localparam int BUSY = 1000;
   localparam int HALF = 6;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       sck   = 1'b0;
   logic       cs    = 1'b1;
   logic       mosi  = 1'b0;
   logic       miso, busy, wel;
   logic [2:0] st;

   int         n_pass  = 0;
   int         n_total = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   qspi_flash_responder #(
      .P_MFR_ID      (8'hEF),
      .P_DEV_ID      (8'h16),
      .P_BUSY_CYCLES (BUSY)
   ) dut (
      .I_clk        (clk),
      .I_rst_n      (rst_n),
      .I_qspi_clk   (sck),
      .I_qspi_cs    (cs),
      .I_qspi_mosi  (mosi),
      .O_qspi_miso  (miso),
      .O_busy       (busy),
      .O_wel        (wel),
      .O_resp_state (st)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic cs_lo();
      @(negedge clk);
      cs = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic cs_hi(input int hold);
      wait_clk(HALF);
      cs   = 1'b1;
      mosi = 1'b0;
      wait_clk(hold);
   endtask

   task automatic send_bits(input logic [7:0] tx, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         mosi = tx[i];
         wait_clk(HALF);
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
   endtask

   task automatic send_byte(input logic [7:0] tx, input logic [7:0] exp);
      exp_q.push_back(exp);
      send_bits(tx, 8);
   endtask

   task automatic send_addr(input logic [7:0] a);
      send_byte(8'h00, 8'h00);
      send_byte(8'h00, 8'h00);
      send_byte(a, 8'h00);
   endtask

   task automatic cmd_only(input logic [7:0] op);
      cs_lo();
      send_byte(op, 8'h00);
      cs_hi(2 * HALF);
   endtask

   task automatic read_status(input logic [7:0] exp);
      cs_lo();
      send_byte(8'h05, 8'h00);
      send_byte(8'h00, exp);
      cs_hi(2 * HALF);
   endtask

   task automatic wait_not_busy();
      int k;
      k = 0;
      while (busy && k < 3 * BUSY) begin
         @(negedge clk);
         k++;
      end
      check("wait_not_busy", {31'b0, busy}, 32'd0);
   endtask

   // Monitor: assembles each MISO byte as the initiator sees it and scores it
   initial begin
      logic [7:0] sh;
      logic [7:0] e;
      int         cnt;
      sh  = '0;
      cnt = 0;
      forever begin
         @(posedge sck or posedge cs);
         if (cs) begin
            cnt = 0;
         end else begin
            sh = {sh[6:0], miso};
            cnt++;
            if (cnt == 8) begin
               cnt = 0;
               n_total++;
               if (exp_q.size() == 0) begin
                  $display("FAIL miso_byte: got 0x%0h, expected nothing queued", sh);
               end else begin
                  e = exp_q.pop_front();
                  if (sh === e) n_pass++;
                  else $display("FAIL miso_byte: got 0x%0h, expected 0x%0h", sh, e);
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      int k;

      wait_clk(3);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_wel", {31'b0, wel}, 32'd0);
      check("rst_state", {29'b0, st}, 32'd0);
      check("rst_miso", {31'b0, miso}, 32'd0);
      rst_n = 1'b1;
      wait_clk(4);

      cs_lo(); send_byte(8'h90, 8'h00); send_addr(8'h00);
      send_byte(8'h00, 8'hEF); send_byte(8'h00, 8'h16); cs_hi(2 * HALF);
      cs_lo(); send_byte(8'h90, 8'h00); send_addr(8'h01);
      send_byte(8'h00, 8'h16); send_byte(8'h00, 8'hEF); cs_hi(2 * HALF);

      read_status(8'h00);
      cmd_only(8'h06);
      check("wel_set", {31'b0, wel}, 32'd1);
      read_status(8'h02);
      cmd_only(8'h04);
      check("wel_clr", {31'b0, wel}, 32'd0);
      read_status(8'h00);

      // Erase and measure the busy window
      cmd_only(8'h06);
      cs_lo(); send_byte(8'h20, 8'h00); send_addr(8'h00); cs_hi(0);
      k = 0;
      while (!busy && k < 50) begin
         @(negedge clk);
         k++;
      end
      cnt = 0;
      while (busy && cnt < 3 * BUSY) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_cycles", cnt, BUSY);
      check("wel_after_erase", {31'b0, wel}, 32'd0);
      wait_clk(2 * HALF);
      cs_lo(); send_byte(8'h03, 8'h00); send_addr(8'h00);
      for (int i = 0; i < 4; i++) send_byte(8'h00, 8'hFF);
      cs_hi(2 * HALF);

      // Program across the wrap, poke the busy window, then read back
      cmd_only(8'h06);
      cs_lo(); send_byte(8'h02, 8'h00); send_addr(8'hFE);
      send_byte(8'hA5, 8'h00); send_byte(8'h5A, 8'h00); send_byte(8'h3C, 8'h00);
      cs_hi(HALF);
      check("prog_busy", {31'b0, busy}, 32'd1);
      read_status(8'h03);
      cs_lo(); send_byte(8'h03, 8'h00); send_addr(8'hFE); send_byte(8'h00, 8'h00);
      cs_hi(2 * HALF);
      check("still_busy", {31'b0, busy}, 32'd1);
      wait_not_busy();
      read_status(8'h00);
      cs_lo(); send_byte(8'h03, 8'h00); send_addr(8'hFE);
      send_byte(8'h00, 8'hA5); send_byte(8'h00, 8'h5A);
      send_byte(8'h00, 8'h3C); send_byte(8'h00, 8'hFF);
      cs_hi(2 * HALF);

      cmd_only(8'h06);
      cs_lo(); send_byte(8'h02, 8'h00); send_addr(8'hFE); send_byte(8'h0F, 8'h00);
      cs_hi(HALF);
      wait_not_busy();
      cs_lo(); send_byte(8'h03, 8'h00); send_addr(8'hFE); send_byte(8'h00, 8'h05);
      cs_hi(2 * HALF);

      // Program without write enable
      cs_lo(); send_byte(8'h02, 8'h00); send_addr(8'h01); send_byte(8'h00, 8'h00);
      cs_hi(HALF);
      check("no_wel_busy", {31'b0, busy}, 32'd0);
      cs_lo(); send_byte(8'h03, 8'h00); send_addr(8'h01); send_byte(8'h00, 8'hFF);
      cs_hi(2 * HALF);

      // Truncated WREN
      cs_lo(); send_bits(8'h06, 7); cs_hi(2 * HALF);
      check("wren_7bits", {31'b0, wel}, 32'd0);

      // Reset in the middle of a read of 0x3C
      cmd_only(8'h06);
      check("wel_before_rst", {31'b0, wel}, 32'd1);
      cs_lo(); send_byte(8'h03, 8'h00); send_addr(8'h00); send_bits(8'h00, 4);
      wait_clk(HALF);
      check("mid_read_state", {29'b0, st}, 32'd3);
      check("mid_read_miso", {31'b0, miso}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_miso", {31'b0, miso}, 32'd0);
      check("rst_mid_state", {29'b0, st}, 32'd0);
      check("rst_mid_wel", {31'b0, wel}, 32'd0);
      wait_clk(2);
      rst_n = 1'b1;
      wait_clk(2);
      cs_hi(2 * HALF);
      read_status(8'h00);

      wait_clk(4);
      check("queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/qspi_flash_responder.md
QSPI_FLASH_RESPONDER -- requirements
Module: qspi_flash_responder

Interface
REQ-001 SHALL have parameter P_MFR_ID, default 8'hEF, manufacturer ID returned by 0x90.
REQ-002 SHALL have parameter P_DEV_ID, default 8'h16, device ID returned by 0x90.
REQ-003 SHALL have parameter P_BUSY_CYCLES, default 64, I_clk cycles BUSY stays set after an erase or program.
REQ-004 SHALL have port I_clk, input, 1, system clock; the only clock in the block.
REQ-005 SHALL have port I_rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port I_qspi_clk, input, 1, SPI serial clock from the initiator, mode 0.
REQ-007 SHALL have port I_qspi_cs, input, 1, chip select, active-low.
REQ-008 SHALL have port I_qspi_mosi, input, 1, serial data from the initiator, MSB first.
REQ-009 SHALL have port O_qspi_miso, output, 1, serial data to the initiator, MSB first.
REQ-010 SHALL have port O_busy, output, 1, status register bit 0 (BUSY).
REQ-011 SHALL have port O_wel, output, 1, status register bit 1 (WEL).
REQ-012 SHALL have port O_resp_state, output, 3, current state encoding, for debug.

Function
REQ-013 Each of I_qspi_clk, I_qspi_cs and I_qspi_mosi SHALL pass through a 2-flop synchronizer on I_clk; SCK edges SHALL be detected on the synchronized copy. I_clk SHALL be at least 4x the SCK frequency.
REQ-014 MOSI SHALL be sampled on SCK rising edges. O_qspi_miso SHALL update on SCK falling edges. O_qspi_miso SHALL be 0 whenever no read data is being shifted out.
REQ-015 The state machine SHALL have the states IDLE, CMD, ADDR, DOUT, DIN and IGNORE.
REQ-016 A falling edge on CS SHALL move IDLE to CMD. A rising edge on CS SHALL return any state to IDLE and discard any partial byte.
REQ-017 After 8 bits in CMD, the next state SHALL be chosen by opcode:
- 0x06, 0x04: IGNORE, action applied at the CS rise.
- 0x05: DOUT.
- 0x90, 0x03, 0x02, 0x20: ADDR.
- Any other opcode: IGNORE.
REQ-018 ADDR SHALL collect 24 bits. Only addr[7:0] SHALL be used, giving a 256-byte memory.
REQ-019 For 0x90, DOUT SHALL return P_MFR_ID then P_DEV_ID and repeat, starting with P_DEV_ID if addr[0]=1.
REQ-020 For 0x05, DOUT SHALL return {6'b0, WEL, BUSY} repeatedly, refreshing the value at each byte boundary.
REQ-021 For 0x03, DOUT SHALL return mem[addr], incrementing addr after each byte and wrapping 0xFF -> 0x00.
REQ-022 For 0x02, DIN SHALL apply mem[addr] <= mem[addr] & byte for each complete byte, then increment addr with wrap-around.
REQ-023 0x02 writes SHALL be enabled only if WEL=1 at the end of the opcode; otherwise bytes SHALL be discarded.
REQ-024 For 0x20, at the CS rise after a complete 24-bit address, if WEL=1 every memory byte SHALL be set to 8'hFF.
REQ-025 At the CS rise after an enabled 0x02 (at least one byte written) or 0x20: BUSY SHALL be set for exactly P_BUSY_CYCLES I_clk cycles, then clear. WEL SHALL clear when BUSY clears.
REQ-026 0x06 SHALL set WEL, and 0x04 SHALL clear WEL, only if CS rises with exactly 8 bits received.
REQ-027 While BUSY=1, only 0x05 SHALL be honored; every other opcode SHALL go to IGNORE with no side effects.
REQ-028 An 0x20 with fewer than 24 address bits SHALL have no effect.
REQ-029 The memory SHALL not be reset; its contents are undefined until the first erase.

Reset
REQ-030 While I_rst_n=0:
- state = IDLE, O_qspi_miso = 0, O_busy = 0, O_wel = 0, O_resp_state = 0.
- Shift registers, bit counter, address and busy counter SHALL be cleared.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction. After release, the block SHALL wait for a fresh CS falling edge.

Verification
REQ-032 0x90 with addr 0, then 16 SCK -> MISO returns 0xEF then 0x16.
REQ-033 0x05 after reset -> 0x00. 0x06 then 0x05 -> 0x02. 0x04 then 0x05 -> 0x00.
REQ-034 0x06, then 0x20 addr 0, then repeated 0x05 -> 0x03 while busy, 0x00 after P_BUSY_CYCLES. Then 0x03 addr 0 -> four bytes of 0xFF.
REQ-035 After an erase: 0x06, then 0x02 addr 0x0000FE with data A5 5A 3C, wait for not-busy, then:
- 0x03 addr 0xFE -> A5 5A 3C (wrap to 0x00).
- A second program of 0x0F to 0xFE -> reads back 0x05.
REQ-036 0x02 without a preceding 0x06 -> memory unchanged and BUSY stays 0. 0x06 with CS raised after 7 bits -> WEL stays 0. 0x03 issued while BUSY -> MISO stays 0.
REQ-037 Reset asserted mid-0x03 read -> O_qspi_miso=0, O_resp_state=IDLE, O_wel=0. The next 0x05 -> 0x00.
